axil_led_ctrl: RTL

AXIL_LED_CTRL -- requirements
Module: axil_led_ctrl

---
 rtl/axil_led_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/axil_led_ctrl.sv
// rtl/axil_led_ctrl.sv - AXI4-Lite LED controller with static and blink modes
// Ports:
//   ACLK, ARESET   clock and synchronous active-high reset
//   S_AXI_AW*/W*/B* AXI4-Lite write channels (4-bit byte address, 32-bit data)
//   S_AXI_AR*/R*    AXI4-Lite read channels
//   leds_o          LED drive, DATA register gated by blink phase
// Registers: 0x0 DATA, 0x4 MODE (bit0 BLINK), 0x8 PERIOD, 0xC STATUS (RO).
module axil_led_ctrl #(
  parameter int          C_NUM_LEDS   = 4,
  parameter logic [31:0] C_PERIOD_RST = 32'd25000000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [3:0]            S_AXI_AWADDR,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [3:0]            S_AXI_ARADDR,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic [C_NUM_LEDS-1:0] leds_o
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_MODE   = 2'd1;
  localparam logic [1:0] A_PERIOD = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [C_NUM_LEDS-1:0] data_r;
  logic                  mode_r;
  logic [31:0]           period_r;
  logic [31:0]           counter_r;
  logic                  phase_r;
  logic [1:0]            bresp_r;
  logic [31:0]           rdata_r;

  logic        wr_en, rd_en, cfg_wr;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] data_ext, wr_old, wr_word, rd_word, term_cnt;
  logic [63:0] status_wide;
  logic        unused_bits;

  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];
  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], status_wide[63:32]};

  // Write FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Address and data are only accepted together, so both readies pulse as one.
  always_comb begin
    S_AXI_AWREADY = (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !ARESET;
    S_AXI_WREADY  = S_AXI_AWREADY;
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BRESP   = bresp_r;
  end

  // Read FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (S_AXI_ARVALID) r_state_nxt = R_DATA;
      R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (r_state == R_IDLE) && !ARESET;
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RDATA   = rdata_r;
    S_AXI_RRESP   = 2'b00;
  end

  assign wr_en  = S_AXI_AWREADY;
  assign rd_en  = S_AXI_ARREADY && S_AXI_ARVALID;
  assign cfg_wr = wr_en && ((wr_sel == A_MODE) || (wr_sel == A_PERIOD));

  // Byte-lane merge of write data into the addressed register's current value.
  always_comb begin
    data_ext = '0;
    data_ext[C_NUM_LEDS-1:0] = data_r;
    case (wr_sel)
      A_DATA:  wr_old = data_ext;
      A_MODE:  wr_old = {31'b0, mode_r};
      default: wr_old = period_r;
    endcase
    wr_word = wr_old;
    for (int b = 0; b < 4; b++) begin
      if (S_AXI_WSTRB[b]) wr_word[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  // STATUS is built wide so that a 32-LED build simply loses the top LED bits.
  always_comb begin
    status_wide = '0;
    status_wide[0] = phase_r;
    status_wide[C_NUM_LEDS+7:8] = leds_o;
    case (rd_sel)
      A_DATA:   rd_word = data_ext;
      A_MODE:   rd_word = {31'b0, mode_r};
      A_PERIOD: rd_word = period_r;
      default:  rd_word = status_wide[31:0];
    endcase
  end

  // Register file and read capture; rd_word reflects pre-write values at this edge.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      data_r   <= '0;
      mode_r   <= 1'b0;
      period_r <= C_PERIOD_RST;
      bresp_r  <= 2'b00;
      rdata_r  <= '0;
    end else begin
      if (wr_en) begin
        bresp_r <= (wr_sel == A_STATUS) ? 2'b10 : 2'b00;
        case (wr_sel)
          A_DATA:   data_r   <= wr_word[C_NUM_LEDS-1:0];
          A_MODE:   mode_r   <= wr_word[0];
          A_PERIOD: period_r <= wr_word;
          default:  ;
        endcase
      end
      if (rd_en) rdata_r <= rd_word;
    end
  end

  // PERIOD of 0 is treated as 1: terminal count 0, phase toggles every cycle.
  assign term_cnt = (period_r == 32'd0) ? 32'd0 : period_r - 32'd1;

  // Blink engine; leds_o is driven from the phase value being registered so
  // that the LEDs and STATUS.PHASE always agree.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      counter_r <= '0;
      phase_r   <= 1'b1;
      leds_o    <= '0;
    end else if (cfg_wr || !mode_r) begin
      counter_r <= '0;
      phase_r   <= 1'b1;
      leds_o    <= data_r;
    end else if (counter_r == term_cnt) begin
      counter_r <= '0;
      phase_r   <= ~phase_r;
      leds_o    <= phase_r ? '0 : data_r;
    end else begin
      counter_r <= counter_r + 32'd1;
      leds_o    <= phase_r ? data_r : '0;
    end
  end

endmodule
